// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU width, split, flag struct and function-bit encoding
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_SPLIT = 16;

    // Function-code bit positions, shared with the compare stage's encoding.
    localparam int ALU_FN_SUB_BIT  = 0;
    localparam int ALU_FN_SIGN_BIT = 1;
    localparam int ALU_FN_W        = 2;

    typedef struct packed {
        logic z;
        logic v;
        logic n;
        logic a31;
    } alu_flags_t;

    // N^V reads as "A less than B" in both sign modes when subtracting.
    function automatic alu_flags_t alu_flags(
        input logic sum_zero,
        input logic sum_msb,
        input logic a_msb,
        input logic bx_msb,
        input logic cout,
        input logic sub,
        input logic sign
    );
        alu_flags_t f;
        f.z   = sum_zero;
        f.a31 = a_msb;
        if (sign) begin
            f.v = (a_msb == bx_msb) && (sum_msb != a_msb);
            f.n = sum_msb;
        end else begin
            f.v = 1'b0;
            f.n = sub ? ~cout : cout;
        end
        return f;
    endfunction

endpackage

// File: rtl/alu_addsub_slice.sv
// rtl/alu_addsub_slice.sv - combinational N-bit adder with carry-in and carry-out
module alu_addsub_slice #(
    parameter int N = 16
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};

endmodule

// File: rtl/alu_addsub_pipe.sv
// rtl/alu_addsub_pipe.sv - two-stage add/sub with flags; ALU_ADDSUB_CARRY_EN adds carry-out port C
module alu_addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SPLIT = ALU_SPLIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Z,
    output logic             V,
    output logic             N,
    output logic             A31
`ifdef ALU_ADDSUB_CARRY_EN
    ,
    output logic             C
`endif
);

    localparam int HI_W = WIDTH - SPLIT;

    logic             s1_valid_q;
    logic [SPLIT-1:0] s1_lo_q;
    logic             s1_c1_q;
    logic [HI_W-1:0]  s1_ahi_q;
    logic [HI_W-1:0]  s1_bxhi_q;
    logic             s1_sub_q;
    logic             s1_sign_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    alu_flags_t       flags_q;
`ifdef ALU_ADDSUB_CARRY_EN
    logic             c_q;
`endif

    logic             advance;
    logic             accept;
    logic [WIDTH-1:0] bx_d;
    logic [SPLIT-1:0] lo_d;
    logic             c1_d;
    logic [HI_W-1:0]  hi_d;
    logic             cout_d;
    logic [WIDTH-1:0] sum_d;
    alu_flags_t       flags_d;

    // Both stages move together whenever the output slot is free or draining.
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || advance;
    assign accept   = in_valid && in_ready;

    assign bx_d = sub ? ~B : B;

    alu_addsub_slice #(.N(SPLIT)) u_lo (
        .a_i    (A[SPLIT-1:0]),
        .b_i    (bx_d[SPLIT-1:0]),
        .cin_i  (sub),
        .sum_o  (lo_d),
        .cout_o (c1_d)
    );

    alu_addsub_slice #(.N(HI_W)) u_hi (
        .a_i    (s1_ahi_q),
        .b_i    (s1_bxhi_q),
        .cin_i  (s1_c1_q),
        .sum_o  (hi_d),
        .cout_o (cout_d)
    );

    assign sum_d   = {hi_d, s1_lo_q};
    assign flags_d = alu_flags(~|sum_d, sum_d[WIDTH-1], s1_ahi_q[HI_W-1],
                               s1_bxhi_q[HI_W-1], cout_d, s1_sub_q, s1_sign_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_lo_q     <= '0;
            s1_c1_q     <= 1'b0;
            s1_ahi_q    <= '0;
            s1_bxhi_q   <= '0;
            s1_sub_q    <= 1'b0;
            s1_sign_q   <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            flags_q     <= '0;
`ifdef ALU_ADDSUB_CARRY_EN
            c_q         <= 1'b0;
`endif
        end else begin
            if (flush) begin
                s1_valid_q  <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                if (in_ready) s1_valid_q <= in_valid;
                if (advance)  out_valid_q <= s1_valid_q;
            end
            if (accept) begin
                s1_lo_q   <= lo_d;
                s1_c1_q   <= c1_d;
                s1_ahi_q  <= A[WIDTH-1:SPLIT];
                s1_bxhi_q <= bx_d[WIDTH-1:SPLIT];
                s1_sub_q  <= sub;
                s1_sign_q <= sign;
            end
            if (advance && s1_valid_q) begin
                sum_q   <= sum_d;
                flags_q <= flags_d;
`ifdef ALU_ADDSUB_CARRY_EN
                c_q     <= cout_d;
`endif
            end
        end
    end

    assign out_valid = out_valid_q;
    assign Sum       = sum_q;
    assign Z         = flags_q.z;
    assign V         = flags_q.v;
    assign N         = flags_q.n;
    assign A31       = flags_q.a31;
`ifdef ALU_ADDSUB_CARRY_EN
    assign C         = c_q;
`endif

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// tb/tb_alu_addsub_pipe.sv - scoreboard bench for alu_addsub_pipe
module tb_alu_addsub_pipe;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, sub, sign, out_valid, out_ready;
    logic [31:0] A, B, Sum;
    logic        Z, V, N, A31;
`ifdef ALU_ADDSUB_CARRY_EN
    logic        C;
`endif

    alu_addsub_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sub       (sub),
        .sign      (sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Z         (Z),
        .V         (V),
        .N         (N),
        .A31       (A31)
`ifdef ALU_ADDSUB_CARRY_EN
        ,
        .C         (C)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic [3:0]  f;
        logic        c;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        sg;
        logic [31:0] sum;
        logic [3:0]  f;
        logic        c;
    } vec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum", Sum, e.sum);
                check("flags_zvna", {28'd0, Z, V, N, A31}, {28'd0, e.f});
`ifdef ALU_ADDSUB_CARRY_EN
                check("carry", {31'd0, C}, {31'd0, e.c});
`endif
                if (e.lat >= 0) check("latency", cyc - e.acc, e.lat);
            end
        end
    end

    // Called at #1 after a rising edge; returns at #1 after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic sg, input logic [31:0] es, input logic [3:0] ef,
                        input logic ec, input int lat);
        exp_t e;
        bit   ok = 0;
        A = a; B = b; sub = s; sign = sg; in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            check("send_timeout", 32'd1, 32'd0);
            in_valid = 1'b0;
            return;
        end
        e.sum = es; e.f = ef; e.c = ec; e.lat = lat; e.acc = cyc;
        exp_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    vec_t vt[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; sub = 1'b0; sign = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b0;
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_sum", Sum, 32'd0);
        check("reset_flags", {28'd0, Z, V, N, A31}, 32'd0);
`ifdef ALU_ADDSUB_CARRY_EN
        check("reset_carry", {31'd0, C}, 32'd0);
`endif
        @(posedge clk); #1;

        vt.push_back('{32'd5,        32'd7,        1'b1, 1'b1, 32'hFFFFFFFE, 4'b0010, 1'b0});
        vt.push_back('{32'h7FFFFFFF, 32'd1,        1'b0, 1'b1, 32'h80000000, 4'b0110, 1'b0});
        vt.push_back('{32'h1234,     32'h1234,     1'b1, 1'b1, 32'h0,        4'b1000, 1'b1});
        vt.push_back('{32'd1,        32'hFFFFFFFF, 1'b1, 1'b0, 32'd2,        4'b0010, 1'b0});
        vt.push_back('{32'hFFFFFFFF, 32'd1,        1'b1, 1'b0, 32'hFFFFFFFE, 4'b0001, 1'b1});
        vt.push_back('{32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 32'h0,        4'b1011, 1'b1});
        vt.push_back('{32'h80000000, 32'd1,        1'b1, 1'b1, 32'h7FFFFFFF, 4'b0101, 1'b1});
        vt.push_back('{32'h0000FFFF, 32'd1,        1'b0, 1'b0, 32'h00010000, 4'b0000, 1'b0});
        vt.push_back('{32'hFFFFFFFE, 32'd3,        1'b0, 1'b1, 32'd1,        4'b0001, 1'b1});
        foreach (vt[i])
            send(vt[i].a, vt[i].b, vt[i].s, vt[i].sg, vt[i].sum, vt[i].f, vt[i].c, 2);
        drain();

        // Back-pressure: only two beats fit while the consumer stalls.
        @(posedge clk); #1 out_ready = 1'b0;
        fork
            begin
                send(32'd10, 32'd1, 1'b0, 1'b0, 32'd11, 4'b0000, 1'b0, -1);
                send(32'd20, 32'd2, 1'b0, 1'b0, 32'd22, 4'b0000, 1'b0, -1);
                send(32'd30, 32'd3, 1'b0, 1'b0, 32'd33, 4'b0000, 1'b0, -1);
                send(32'd40, 32'd4, 1'b0, 1'b0, 32'd44, 4'b0000, 1'b0, -1);
            end
            begin
                repeat (5) @(negedge clk);
                check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
                check("bp_out_valid", {31'd0, out_valid}, 32'd1);
                check("bp_sum_hold", Sum, 32'd11);
                @(negedge clk);
                check("bp_sum_stable", Sum, 32'd11);
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();

        // Flush with both stages full and a beat presented.
        @(posedge clk); #1 out_ready = 1'b0;
        send(32'd50, 32'd5, 1'b0, 1'b0, 32'd55, 4'b0000, 1'b0, -1);
        send(32'd60, 32'd6, 1'b0, 1'b0, 32'd66, 4'b0000, 1'b0, -1);
        check("full_in_ready_low", {31'd0, in_ready}, 32'd0);
        A = 32'd70; B = 32'd7; sub = 1'b0; sign = 1'b0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("flush_no_output", {31'd0, out_valid}, 32'd0);

        // Flush beats an accept into an empty pipe.
        A = 32'd80; B = 32'd8; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 check("flush_drop_accept", {31'd0, out_valid}, 32'd0);
        end

        // Asynchronous reset between edges with a result on the output.
        send(32'd100, 32'd1, 1'b0, 1'b0, 32'd101, 4'b0000, 1'b0, -1);
        send(32'd200, 32'd2, 1'b0, 1'b0, 32'd202, 4'b0000, 1'b0, -1);
        #2 check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        exp_q.delete();
        #1 check("async_reset_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #3 reset = 1'b0;
        @(posedge clk); #1;
        send(32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h01234567, 4'b0000, 1'b1, 2);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
